// File: rtl/pwm_pkg.sv
// Shared constants for the RGB PWM driver: channel width, phase range, colour-word slices.
// Latency: n/a (package only).
// Backpressure: n/a.
package pwm_pkg;

   // Width of one colour channel and of the phase counter
   localparam int CH_W = 8;

   // Last phase of a period; 255 is never reached, so duty 255 means always high
   localparam logic [CH_W-1:0] PHASE_MAX = 8'd254;

   // Bit positions of each channel inside the 24-bit light word {R,G,B}
   localparam int R_HI = 23;
   localparam int R_LO = 16;
   localparam int G_HI = 15;
   localparam int G_LO = 8;
   localparam int B_HI = 7;
   localparam int B_LO = 0;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow duty register plus registered phase compare.
// Latency: 1 clk from phase/shadow to pwm_out.
// Backpressure: none; duty_in is sampled whenever load is high.
module pwm_channel
   import pwm_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic            load,
   input  logic [CH_W-1:0] duty_in,
   input  logic [CH_W-1:0] phase,
   output logic            pwm_out
);

   logic [CH_W-1:0] shadow;

   // Shadow duty: only changes on a load, so a period never sees a mid-period duty change
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow <= '0;
      end else if (load) begin
         shadow <= duty_in;
      end
   end

   // Registered compare: high for phases 0..duty-1, forced low while disabled
   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_out <= 1'b0;
      end else begin
         pwm_out <= enable && (phase < shadow);
      end
   end

endmodule

// File: rtl/rgb_pwm_driver.sv
// RGB PWM driver: prescaler, 255-tick phase counter, period framing and three PWM channels.
// Latency: 1 clk from phase to pwm_r/g/b; a new colour takes effect at the next period.
// Backpressure: none; light is sampled every cycle while disabled, else only at the wrap.
module rgb_pwm_driver
   import pwm_pkg::*;
#(
   parameter int PRESCALE = 1,
   parameter int PRE_W    = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic [23:0] light,
   output logic        pwm_r,
   output logic        pwm_g,
   output logic        pwm_b,
   output logic        period_start
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic [CH_W-1:0]  phase;
   logic             tick;
   logic             wrap;
   logic             load;

   // Tick on the last prescaler count; wrap on the tick that ends phase 254
   always_comb begin
      tick = enable && (pre_cnt == PRE_LAST);
      wrap = tick && (phase == PHASE_MAX);
      load = !enable || wrap;
   end

   // Prescaler: counts 0..PRESCALE-1, held at 0 while disabled
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PRE_W'(1);
      end
   end

   // Phase counter: 0..254 on ticks, restarts at 0 whenever disabled
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         phase <= '0;
      end else if (tick) begin
         phase <= wrap ? '0 : phase + 8'd1;
      end
   end

   // Period marker: lands in the first cycle of phase 0 after a wrap (not on re-enable)
   always_ff @(posedge clk) begin
      if (rst) begin
         period_start <= 1'b0;
      end else begin
         period_start <= wrap;
      end
   end

   pwm_channel u_red (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .load    (load),
      .duty_in (light[R_HI:R_LO]),
      .phase   (phase),
      .pwm_out (pwm_r)
   );

   pwm_channel u_green (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .load    (load),
      .duty_in (light[G_HI:G_LO]),
      .phase   (phase),
      .pwm_out (pwm_g)
   );

   pwm_channel u_blue (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .load    (load),
      .duty_in (light[B_HI:B_LO]),
      .phase   (phase),
      .pwm_out (pwm_b)
   );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: two instances (PRESCALE 1 and 4) sharing rst/enable.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: n/a.
module tb_rgb_pwm_driver;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [23:0] light1;
   logic [23:0] light4;
   logic        pwm_r1, pwm_g1, pwm_b1, period_start1;
   logic        pwm_r4, pwm_g4, pwm_b4, period_start4;

   always #5 clk = ~clk;

   rgb_pwm_driver #(.PRESCALE(1), .PRE_W(16)) dut1 (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .light        (light1),
      .pwm_r        (pwm_r1),
      .pwm_g        (pwm_g1),
      .pwm_b        (pwm_b1),
      .period_start (period_start1)
   );

   rgb_pwm_driver #(.PRESCALE(4), .PRE_W(16)) dut4 (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .light        (light4),
      .pwm_r        (pwm_r4),
      .pwm_g        (pwm_g4),
      .pwm_b        (pwm_b4),
      .period_start (period_start4)
   );

   typedef struct packed { logic r; logic g; logic b; logic ps; } exp_t;
   typedef struct packed { exp_t d1; exp_t d4; } pair_t;
   typedef struct {
      logic [23:0] light;
      int          er;
      int          eg;
      int          eb;
      int          eps;
      string       name;
   } vec_t;

   pair_t       sbq[$];
   int          n_vec = 0;
   int          n_bad = 0;
   int          m_pre [2];
   int          m_ph  [2];
   logic [23:0] m_sh  [2];
   int          c_r1, c_g1, c_b1, c_ps1, c_r4, c_g4, c_b4, c_ps4, last_ps4;
   int          wait_len, wait_b1, b_sum;
   vec_t        tbl [5];

   function automatic int ps_of(input int i);
      return (i == 0) ? 1 : 4;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge, written from the behavioural description
   task automatic model_step(input int i, input logic [23:0] lt, output exp_t e);
      logic tick;
      logic wrap;
      e = '0;
      if (rst) begin
         m_pre[i] = 0;
         m_ph[i]  = 0;
         m_sh[i]  = '0;
      end else begin
         tick = enable && (m_pre[i] == ps_of(i) - 1);
         wrap = tick && (m_ph[i] == 254);
         e.r  = enable && (m_ph[i] < int'(m_sh[i][23:16]));
         e.g  = enable && (m_ph[i] < int'(m_sh[i][15:8]));
         e.b  = enable && (m_ph[i] < int'(m_sh[i][7:0]));
         e.ps = wrap;
         if (!enable || wrap) m_sh[i] = lt;
         if (!enable) begin
            m_pre[i] = 0;
            m_ph[i]  = 0;
         end else if (tick) begin
            m_pre[i] = 0;
            m_ph[i]  = wrap ? 0 : m_ph[i] + 1;
         end else begin
            m_pre[i] = m_pre[i] + 1;
         end
      end
   endtask

   // One clock: push the expected outputs, let the edge happen, pop and compare
   task automatic step();
      pair_t p;
      exp_t  a1;
      exp_t  a4;
      model_step(0, light1, p.d1);
      model_step(1, light4, p.d4);
      sbq.push_back(p);
      @(posedge clk);
      #1;
      p  = sbq.pop_front();
      a1 = {pwm_r1, pwm_g1, pwm_b1, period_start1};
      a4 = {pwm_r4, pwm_g4, pwm_b4, period_start4};
      chk("sb_dut1{r,g,b,ps}", 32'(a1), 32'(p.d1));
      chk("sb_dut4{r,g,b,ps}", 32'(a4), 32'(p.d4));
   endtask

   // Count high cycles on every output over n clocks
   task automatic window(input int n);
      c_r1 = 0; c_g1 = 0; c_b1 = 0; c_ps1 = 0;
      c_r4 = 0; c_g4 = 0; c_b4 = 0; c_ps4 = 0;
      last_ps4 = 0;
      for (int k = 1; k <= n; k++) begin
         step();
         c_r1 += int'(pwm_r1);  c_g1 += int'(pwm_g1);
         c_b1 += int'(pwm_b1);  c_ps1 += int'(period_start1);
         c_r4 += int'(pwm_r4);  c_g4 += int'(pwm_g4);
         c_b4 += int'(pwm_b4);  c_ps4 += int'(period_start4);
         if (period_start4 === 1'b1) last_ps4 = k;
      end
   endtask

   task automatic wait_ps1(input int budget);
      wait_len = 0;
      wait_b1  = 0;
      do begin
         step();
         wait_len++;
         wait_b1 += int'(pwm_b1);
      end while (period_start1 !== 1'b1 && wait_len < budget);
      if (period_start1 !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_ps1: no period_start1 within %0d cycles, expected one", budget);
      end
   endtask

   task automatic wait_ps4(input int budget);
      int w;
      w = 0;
      do begin
         step();
         w++;
      end while (period_start4 !== 1'b1 && w < budget);
      if (period_start4 !== 1'b1) begin
         n_vec++;
         n_bad++;
         $display("FAIL wait_ps4: no period_start4 within %0d cycles, expected one", budget);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Duty table: light loaded at a wrap, counts taken over the following full period
      tbl[0] = '{24'h00FF80,   0, 255, 128, 1, "tbl_00FF80"};
      tbl[1] = '{24'h7F0180, 127,   1, 128, 1, "tbl_7F0180"};
      tbl[2] = '{24'h010000,   1,   0,   0, 1, "tbl_010000"};
      tbl[3] = '{24'h000000,   0,   0,   0, 1, "tbl_000000"};
      tbl[4] = '{24'hFFFFFF, 255, 255, 255, 1, "tbl_FFFFFF"};

      rst    = 1'b1;
      enable = 1'b0;
      light1 = 24'h00FF80;
      light4 = 24'h010000;

      // Reset state
      repeat (3) step();
      chk("reset_pwm_r", 32'(pwm_r1), 32'd0);
      chk("reset_pwm_g", 32'(pwm_g1), 32'd0);
      chk("reset_pwm_b", 32'(pwm_b1), 32'd0);
      chk("reset_period_start", 32'(period_start1), 32'd0);
      rst = 1'b0;
      repeat (2) step();
      enable = 1'b1;

      // PRESCALE=4: period of 1020 clocks, red duty 1 -> 4 high clocks
      wait_ps4(1100);
      window(1020);
      chk("p4_red_high", 32'(c_r4), 32'd4);
      chk("p4_green_high", 32'(c_g4), 32'd0);
      chk("p4_blue_high", 32'(c_b4), 32'd0);
      chk("p4_period_pulses", 32'(c_ps4), 32'd1);
      chk("p4_period_len", 32'(last_ps4), 32'd1020);

      // Table of steady duty values on the PRESCALE=1 instance
      for (int t = 0; t < 5; t++) begin
         light1 = tbl[t].light;
         wait_ps1(600);
         window(255);
         chk({tbl[t].name, "_r"}, 32'(c_r1), 32'(tbl[t].er));
         chk({tbl[t].name, "_g"}, 32'(c_g1), 32'(tbl[t].eg));
         chk({tbl[t].name, "_b"}, 32'(c_b1), 32'(tbl[t].eb));
         chk({tbl[t].name, "_ps"}, 32'(c_ps1), 32'(tbl[t].eps));
      end

      // Full duty across a second period: no low gap at the wrap
      window(255);
      chk("nogap_r", 32'(c_r1), 32'd255);
      chk("nogap_b", 32'(c_b1), 32'd255);

      // Mid-period colour change is deferred to the next period
      light1 = 24'h0000FF;
      wait_ps1(600);
      window(100);
      b_sum  = c_b1;
      light1 = 24'h000010;
      window(155);
      b_sum += c_b1;
      chk("midchange_cur_b", 32'(b_sum), 32'd255);
      window(255);
      chk("midchange_next_b", 32'(c_b1), 32'd16);

      // Disable mid-period, then re-enable with a new colour
      light1 = 24'h0000FF;
      wait_ps1(600);
      window(50);
      chk("dis_before_b", 32'(pwm_b1), 32'd1);
      enable = 1'b0;
      light1 = 24'h000003;
      step();
      chk("dis_next_rgb", 32'({pwm_r1, pwm_g1, pwm_b1}), 32'd0);
      chk("dis_next_ps", 32'(period_start1), 32'd0);
      repeat (3) step();
      enable = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk($sformatf("reen_b_cyc%0d", k), 32'(pwm_b1), (k <= 3) ? 32'd1 : 32'd0);
         chk($sformatf("reen_ps_cyc%0d", k), 32'(period_start1), 32'd0);
      end

      // One-cycle reset mid-period with enable held high
      light1 = 24'h0000FF;
      wait_ps1(600);
      window(80);
      rst    = 1'b1;
      light1 = 24'h000020;
      step();
      chk("rst_mid_dut1", 32'({pwm_r1, pwm_g1, pwm_b1, period_start1}), 32'd0);
      chk("rst_mid_dut4", 32'({pwm_r4, pwm_g4, pwm_b4, period_start4}), 32'd0);
      rst = 1'b0;
      wait_ps1(600);
      chk("rst_first_period_len", 32'(wait_len), 32'd255);
      chk("rst_first_period_b", 32'(wait_b1), 32'd0);
      window(255);
      chk("rst_second_period_b", 32'(c_b1), 32'd32);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
